// File: rtl/present_enc_core_pkg.sv
// PRESENT cipher primitives shared by the round logic and the encryption core:
// S-box, permutation layer, key-schedule updates and the core FSM encoding.
package present_pkg;

    localparam int unsigned ROUNDS = 31;
    // Nibble i of SBOX holds S(i).
    localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] sbox_layer64(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] p_layer64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        y[63] = x[63];
        for (int j = 0; j < 63; j++) y[(16 * j) % 63] = x[j];
        return y;
    endfunction

    function automatic logic [79:0] key_update80(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox4(r[79:76]);
        r[19:15] = r[19:15] ^ rc;
        return r;
    endfunction

    function automatic logic [127:0] key_update128(input logic [127:0] k, input logic [4:0] rc);
        logic [127:0] r;
        r = {k[66:0], k[127:67]};
        r[127:124] = sbox4(r[127:124]);
        r[123:120] = sbox4(r[123:120]);
        r[66:62]   = r[66:62] ^ rc;
        return r;
    endfunction

endpackage

// File: rtl/present_enc_core_if.sv
// Valid/ready handshake bundle for the PRESENT core: plaintext/key in, ciphertext out.
interface present_enc_core_if #(
    parameter int unsigned KEY_W = 80
) ();
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_text;
    logic [KEY_W-1:0] in_key;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_text;

    modport master (
        output in_valid, in_text, in_key, out_ready,
        input  in_ready, out_valid, out_text
    );

    modport slave (
        input  in_valid, in_text, in_key, out_ready,
        output in_ready, out_valid, out_text
    );
endinterface

// File: rtl/present_enc_core_round.sv
// One combinational PRESENT round plus key update; when en_i is low the stage is a bypass.
module present_round
    import present_pkg::*;
#(
    parameter int unsigned KEY_W = 80
) (
    input  logic             en_i,
    input  logic [4:0]       rc_i,
    input  logic [63:0]      state_i,
    input  logic [KEY_W-1:0] key_i,
    output logic [63:0]      state_o,
    output logic [KEY_W-1:0] key_o
);
    logic [63:0]      state_rnd;
    logic [KEY_W-1:0] key_rnd;

    assign state_rnd = p_layer64(sbox_layer64(state_i ^ key_i[KEY_W-1 -: 64]));

    if (KEY_W == 128) begin : g_key128
        assign key_rnd = key_update128(key_i, rc_i);
    end else begin : g_key80
        assign key_rnd = key_update80(key_i, rc_i);
    end

    assign state_o = en_i ? state_rnd : state_i;
    assign key_o   = en_i ? key_rnd   : key_i;
endmodule

// File: rtl/present_enc_core.sv
// Iterative PRESENT encryption core: UNROLL chained rounds per clock, 31 rounds plus
// final whitening, valid/ready handshakes on input and output.
module present_enc_core
    import present_pkg::*;
#(
    parameter int unsigned KEY_W  = 80,
    parameter int unsigned UNROLL = 1
) (
    input logic               clk,
    input logic               rst_n,
    present_enc_core_if.slave bus
);
    if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
        $fatal(1, "present_enc_core: KEY_W must be 80 or 128");
    end
    if (UNROLL == 0 || UNROLL > ROUNDS) begin : g_bad_unroll
        $fatal(1, "present_enc_core: UNROLL must be in 1..31");
    end

    state_e           fsm_q, fsm_d;
    logic [63:0]      state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [5:0]       rc_q, rc_d;
    logic [63:0]      out_text_q, out_text_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [63:0]      st_chain  [UNROLL+1];
    logic [KEY_W-1:0] key_chain [UNROLL+1];

    assign st_chain[0]  = state_q;
    assign key_chain[0] = key_q;

    // Stages whose round index would exceed 31 are bypassed on the final cycle.
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        logic [6:0] rc_stage;
        assign rc_stage = {1'b0, rc_q} + 7'(g);
        present_round #(
            .KEY_W(KEY_W)
        ) u_round (
            .en_i    (rc_stage <= 7'(ROUNDS)),
            .rc_i    (rc_stage[4:0]),
            .state_i (st_chain[g]),
            .key_i   (key_chain[g]),
            .state_o (st_chain[g+1]),
            .key_o   (key_chain[g+1])
        );
    end

    logic [6:0] rc_ext, rc_remain, rc_step;
    logic       last_step;

    assign rc_ext    = {1'b0, rc_q};
    assign rc_remain = 7'd32 - rc_ext;
    assign rc_step   = (7'(UNROLL) < rc_remain) ? 7'(UNROLL) : rc_remain;
    assign last_step = (rc_ext + 7'(UNROLL)) >= 7'd32;

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        key_d      = key_q;
        rc_d       = rc_q;
        out_text_d = out_text_q;
        unique case (fsm_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d = bus.in_text;
                    key_d   = bus.in_key;
                    rc_d    = 6'd1;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                state_d = st_chain[UNROLL];
                key_d   = key_chain[UNROLL];
                rc_d    = 6'(rc_ext + rc_step);
                if (last_step) begin
                    out_text_d = st_chain[UNROLL] ^ key_chain[UNROLL][KEY_W-1 -: 64];
                    fsm_d      = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) fsm_d = StIdle;
            end
            default: fsm_d = StIdle;
        endcase
        in_ready_d  = (fsm_d == StIdle);
        out_valid_d = (fsm_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            key_q       <= '0;
            rc_q        <= '0;
            out_text_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_q       <= key_d;
            rc_q        <= rc_d;
            out_text_q  <= out_text_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_text  = out_text_q;
endmodule

// File: tb/tb_present_enc_core.sv
// Bench for present_enc_core: five instances (80/1, 80/4, 80/31, 128/1, 128/3) share stimulus;
// instance 0 carries the handshake, reset and back-to-back scenarios.
module tb_present_enc_core;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [63:0]  in_text = '0;
    logic [79:0]  key80 = '0;
    logic [127:0] key128 = '0;
    logic         out_ready = 1'b0;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    present_enc_core_if #(.KEY_W(80))  if_a ();
    present_enc_core_if #(.KEY_W(80))  if_b ();
    present_enc_core_if #(.KEY_W(80))  if_c ();
    present_enc_core_if #(.KEY_W(128)) if_d ();
    present_enc_core_if #(.KEY_W(128)) if_e ();

    assign if_a.in_valid = in_valid; assign if_a.in_text = in_text;
    assign if_a.in_key = key80;      assign if_a.out_ready = out_ready;
    assign if_b.in_valid = in_valid; assign if_b.in_text = in_text;
    assign if_b.in_key = key80;      assign if_b.out_ready = out_ready;
    assign if_c.in_valid = in_valid; assign if_c.in_text = in_text;
    assign if_c.in_key = key80;      assign if_c.out_ready = out_ready;
    assign if_d.in_valid = in_valid; assign if_d.in_text = in_text;
    assign if_d.in_key = key128;     assign if_d.out_ready = out_ready;
    assign if_e.in_valid = in_valid; assign if_e.in_text = in_text;
    assign if_e.in_key = key128;     assign if_e.out_ready = out_ready;

    present_enc_core #(.KEY_W(80),  .UNROLL(1))  u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    present_enc_core #(.KEY_W(80),  .UNROLL(4))  u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    present_enc_core #(.KEY_W(80),  .UNROLL(31)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
    present_enc_core #(.KEY_W(128), .UNROLL(1))  u_dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));
    present_enc_core #(.KEY_W(128), .UNROLL(3))  u_dut_e (.clk(clk), .rst_n(rst_n), .bus(if_e));

    logic [4:0]  ov, ir;
    logic [63:0] ot [5];
    assign ov = {if_e.out_valid, if_d.out_valid, if_c.out_valid, if_b.out_valid, if_a.out_valid};
    assign ir = {if_e.in_ready, if_d.in_ready, if_c.in_ready, if_b.in_ready, if_a.in_ready};
    assign ot[0] = if_a.out_text;
    assign ot[1] = if_b.out_text;
    assign ot[2] = if_c.out_text;
    assign ot[3] = if_d.out_text;
    assign ot[4] = if_e.out_text;

    localparam logic [63:0] CT_Z80  = 64'h5579_C138_7B22_8445;
    localparam logic [63:0] CT_Z128 = 64'h96DB_702A_2E69_00AF;

    function automatic int exp_lat(input int i);
        case (i)
            0: return 31;
            1: return 8;
            2: return 1;
            3: return 31;
            default: return 11;
        endcase
    endfunction

    function automatic logic [3:0] tb_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] ref_enc80(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s, t;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int i = 0; i < 16; i++) s[4*i +: 4] = tb_sbox(s[4*i +: 4]);
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
            s = t;
            k = (k << 61) | (k >> 19);
            k[79:76] = tb_sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (ir !== 5'b0) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=%b", ir, 5'b0);
        end
        checks++;
        if (ov !== 5'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=%b", ov, 5'b0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ot[i] !== 64'h0) begin
                failures++; $display("FAIL reset_out_text[%0d] got=%h exp=0", i, ot[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ir !== 5'b11111) begin
            failures++; $display("FAIL release_in_ready got=%b exp=%b", ir, 5'b11111);
        end
    endtask

    task automatic test_vectors();
        logic [63:0] txt [4];
        logic [79:0] kys [4];
        logic [63:0] exp80 [4];
        int          lat [5];
        logic [63:0] got [5];
        txt   = '{64'h0, 64'h0, {64{1'b1}}, {64{1'b1}}};
        kys   = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
        exp80 = '{CT_Z80, 64'hE72C_46C0_F594_5049, 64'hA112_FFC7_2F68_417B,
                  64'h3333_DCD3_2132_10D2};
        do_reset();
        for (int v = 0; v < 4; v++) begin
            in_text = txt[v];
            key80 = kys[v];
            key128 = '0;
            out_ready = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < 5; i++) begin
                lat[i] = -1;
                got[i] = '0;
            end
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    if (ov[i] && lat[i] < 0) begin
                        lat[i] = k;
                        got[i] = ot[i];
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp80[v]) begin
                    failures++;
                    $display("FAIL vec%0d_dut%0d_text got=%h exp=%h", v, i, got[i], exp80[v]);
                end
                checks++;
                if (lat[i] != exp_lat(i)) begin
                    failures++;
                    $display("FAIL vec%0d_dut%0d_latency got=%0d exp=%0d", v, i, lat[i], exp_lat(i));
                end
            end
            if (v == 0) begin
                for (int i = 3; i < 5; i++) begin
                    checks++;
                    if (got[i] !== CT_Z128) begin
                        failures++;
                        $display("FAIL k128_dut%0d_text got=%h exp=%h", i, got[i], CT_Z128);
                    end
                    checks++;
                    if (lat[i] != exp_lat(i)) begin
                        failures++;
                        $display("FAIL k128_dut%0d_latency got=%0d exp=%0d", i, lat[i], exp_lat(i));
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [63:0] got;
        do_reset();
        out_ready = 1'b0;
        in_text = '0;
        key80 = '0;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ir[0] !== 1'b0) begin
            failures++; $display("FAIL bp_ready_after_accept got=%b exp=0", ir[0]);
        end
        lat = -1;
        got = '0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            in_text = {32'(k), ~32'(k)};
            key80 = {16'(k), 64'hFFFF_0000_1234_5678};
            @(negedge clk);
            if (ov[0]) begin
                lat = k;
                got = ot[0];
            end
        end
        checks++;
        if (lat != 31) begin
            failures++; $display("FAIL bp_latency got=%0d exp=31", lat);
        end
        checks++;
        if (got !== CT_Z80) begin
            failures++; $display("FAIL bp_text got=%h exp=%h", got, CT_Z80);
        end
        for (int k = 0; k < 5; k++) begin
            in_text = ~in_text;
            key80 = ~key80;
            @(negedge clk);
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
                failures++;
                $display("FAIL hold%0d_handshake got=v%b/r%b exp=v1/r0", k, ov[0], ir[0]);
            end
            checks++;
            if (ot[0] !== CT_Z80) begin
                failures++; $display("FAIL hold%0d_text got=%h exp=%h", k, ot[0], CT_Z80);
            end
        end
        in_text = '1;
        key80 = '0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_consume got=v%b/r%b exp=v0/r1", ov[0], ir[0]);
        end
        @(negedge clk);
        checks++;
        if (ir[0] !== 1'b0) begin
            failures++; $display("FAIL bp_second_accept got=%b exp=0", ir[0]);
        end
        in_valid = 1'b0;
        lat = -1;
        got = '0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (ov[0]) begin
                lat = k;
                got = ot[0];
            end
        end
        checks++;
        if (got !== 64'hA112_FFC7_2F68_417B || lat != 31) begin
            failures++;
            $display("FAIL bp_second_block got=%h@%0d exp=a112ffc72f68417b@31", got, lat);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [63:0] got;
        do_reset();
        in_text = '0;
        key80 = '0;
        key128 = '0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (ov[2] !== 1'b1 || ot[2] !== CT_Z80) begin
            failures++;
            $display("FAIL mid_precond_u31 got=v%b/%h exp=v1/%h", ov[2], ot[2], CT_Z80);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov !== 5'b0 || ir !== 5'b0) begin
            failures++; $display("FAIL mid_reset_flags got=v%b/r%b exp=v0/r0", ov, ir);
        end
        checks++;
        if (ot[0] !== 64'h0 || ot[2] !== 64'h0) begin
            failures++; $display("FAIL mid_reset_text got=%h/%h exp=0/0", ot[0], ot[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        got = '0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (ov[0]) begin
                lat = k;
                got = ot[0];
            end
        end
        checks++;
        if (got !== CT_Z80 || lat != 31) begin
            failures++;
            $display("FAIL mid_after_reset got=%h@%0d exp=%h@31", got, lat, CT_Z80);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] pt, exp_ct, got;
        logic [79:0] k;
        logic        acc, got_one;
        int          n_out;
        do_reset();
        n_out = 0;
        for (int v = 0; v < 20; v++) begin
            pt = {$urandom, $urandom};
            k = {16'($urandom), $urandom, $urandom};
            exp_ct = ref_enc80(pt, k);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            in_text = pt;
            key80 = k;
            in_valid = 1'b1;
            acc = 1'b0;
            for (int c = 0; c < 60 && !acc; c++) begin
                if (ir[0]) acc = 1'b1;
                @(negedge clk);
            end
            in_valid = 1'b0;
            got_one = 1'b0;
            got = '0;
            for (int c = 0; c < 100 && acc && !got_one; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (ov[0] && out_ready) begin
                    got = ot[0];
                    got_one = 1'b1;
                    n_out++;
                end
                @(negedge clk);
            end
            checks++;
            if (!got_one || got !== exp_ct) begin
                failures++;
                $display("FAIL b2b%0d_text got=%h(seen=%b) exp=%h", v, got, got_one, exp_ct);
            end
            checks++;
            if (ov[0] !== 1'b0) begin
                failures++; $display("FAIL b2b%0d_duplicate got=%b exp=0", v, ov[0]);
            end
        end
        checks++;
        if (n_out != 20) begin
            failures++; $display("FAIL b2b_count got=%0d exp=20", n_out);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
